// File: rtl/key_cond_pkg.sv
// Shared types and helpers for the push-button conditioner.
package key_cond_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    LONG,
    RELEASE_WAIT
  } key_state_e;

  // Pin level seen when the button is not pressed.
  function automatic logic released_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for an asynchronous input, with a configurable reset value.
module key_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      meta <= RST_VAL;
      q_o  <= RST_VAL;
    end else begin
      meta <= d_i;
      q_o  <= meta;
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Push-button conditioner: synchronise, debounce, press/release/long pulses, sticky flags, counter.
// Optional auto-repeat while held in LONG is enabled by defining KEY_AUTO_REPEAT_EN.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
  parameter int unsigned LONG_PRESS_CYCLES = 50000000,
  parameter int unsigned REPEAT_CYCLES     = 10000000,
  parameter int unsigned CNT_W             = 16,
  parameter bit          ACTIVE_LOW        = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             key_raw_i,
  input  logic             evt_clr_i,
  input  logic             cnt_clr_i,
  output logic             key_level_o,
  output logic             press_pulse_o,
  output logic             release_pulse_o,
  output logic             long_pulse_o,
  output logic             press_evt_o,
  output logic             long_evt_o,
  output logic [CNT_W-1:0] press_cnt_o
);

  localparam int unsigned DB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = cnt_width(LONG_PRESS_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  // Reject degenerate cycle counts at elaboration.
  if (DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("key_conditioner: cycle parameters must be at least 1");
  end

  logic key_s;
  logic k;

  key_sync #(
    .RST_VAL(released_level(ACTIVE_LOW))
  ) u_sync (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .d_i    (key_raw_i),
    .q_o    (key_s)
  );

  assign k = key_s ^ ACTIVE_LOW;

  key_state_e        state_q, state_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              was_long_q, was_long_d;
  logic              press_p_d, release_p_d, long_p_d;

`ifdef KEY_AUTO_REPEAT_EN
  localparam int unsigned RPT_W = cnt_width(REPEAT_CYCLES);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
`endif

  // Next-state and pulse decode.
  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    was_long_d  = was_long_q;
    press_p_d   = 1'b0;
    release_p_d = 1'b0;
    long_p_d    = 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
    rpt_cnt_d   = rpt_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (k) begin
          state_d  = PRESS_WAIT;
          db_cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!k) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = PRESSED;
          press_p_d  = 1'b1;
          hold_cnt_d = '0;
          was_long_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      PRESSED: begin
        if (!k) begin
          state_d  = RELEASE_WAIT;
          db_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = LONG;
          long_p_d   = 1'b1;
          was_long_d = 1'b1;
`ifdef KEY_AUTO_REPEAT_EN
          rpt_cnt_d  = '0;
`endif
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      LONG: begin
        if (!k) begin
          state_d  = RELEASE_WAIT;
          db_cnt_d = '0;
        end
`ifdef KEY_AUTO_REPEAT_EN
        else if (rpt_cnt_q == RPT_LAST) begin
          press_p_d = 1'b1;
          rpt_cnt_d = '0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
        end
`endif
      end
      RELEASE_WAIT: begin
        // A bounce back to pressed resumes where it left off; hold_cnt is kept.
        if (k) begin
          state_d = was_long_q ? LONG : PRESSED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = IDLE;
          release_p_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q         <= IDLE;
      db_cnt_q        <= '0;
      hold_cnt_q      <= '0;
      was_long_q      <= 1'b0;
      key_level_o     <= 1'b0;
      press_pulse_o   <= 1'b0;
      release_pulse_o <= 1'b0;
      long_pulse_o    <= 1'b0;
      press_evt_o     <= 1'b0;
      long_evt_o      <= 1'b0;
      press_cnt_o     <= '0;
`ifdef KEY_AUTO_REPEAT_EN
      rpt_cnt_q       <= '0;
`endif
    end else begin
      state_q         <= state_d;
      db_cnt_q        <= db_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      was_long_q      <= was_long_d;
      key_level_o     <= (state_d == PRESSED) || (state_d == LONG) || (state_d == RELEASE_WAIT);
      press_pulse_o   <= press_p_d;
      release_pulse_o <= release_p_d;
      long_pulse_o    <= long_p_d;
      press_evt_o     <= press_p_d | (press_evt_o & ~evt_clr_i);
      long_evt_o      <= long_p_d | (long_evt_o & ~evt_clr_i);
      // A clear coinciding with a press keeps that press.
      press_cnt_o     <= cnt_clr_i ? CNT_W'(press_p_d) : press_cnt_o + CNT_W'(press_p_d);
`ifdef KEY_AUTO_REPEAT_EN
      rpt_cnt_q       <= rpt_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: per-cycle vector table plus multi-cycle corner sequences.
module tb_key_conditioner;

  localparam int unsigned CNT_W = 16;

  logic             clk_i;
  logic             rst_n_i;
  logic             key_raw_i;
  logic             evt_clr_i;
  logic             cnt_clr_i;
  logic             key_level_o;
  logic             press_pulse_o;
  logic             release_pulse_o;
  logic             long_pulse_o;
  logic             press_evt_o;
  logic             long_evt_o;
  logic [CNT_W-1:0] press_cnt_o;

  key_conditioner #(
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(16),
    .REPEAT_CYCLES    (8),
    .CNT_W            (CNT_W),
    .ACTIVE_LOW       (1'b1)
  ) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .key_raw_i      (key_raw_i),
    .evt_clr_i      (evt_clr_i),
    .cnt_clr_i      (cnt_clr_i),
    .key_level_o    (key_level_o),
    .press_pulse_o  (press_pulse_o),
    .release_pulse_o(release_pulse_o),
    .long_pulse_o   (long_pulse_o),
    .press_evt_o    (press_evt_o),
    .long_evt_o     (long_evt_o),
    .press_cnt_o    (press_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // flags = {level, press, release, long, press_evt, long_evt}
  typedef struct {
    logic       raw;
    logic       evt_clr;
    logic       cnt_clr;
    logic [5:0] flags;
    int         cnt;
  } vec_t;

  localparam int SIG_PRESS = 0;
  localparam int SIG_REL   = 1;
  localparam int SIG_LONG  = 2;

`ifdef KEY_AUTO_REPEAT_EN
  localparam int EXP_REPEATS = 5;
`else
  localparam int EXP_REPEATS = 0;
`endif

  int errors = 0;
  int checks = 0;
  int press_seen = 0;
  int rel_seen = 0;
  int long_seen = 0;
  int overlap_seen = 0;

  always @(negedge clk_i) begin
    if (press_pulse_o) press_seen++;
    if (release_pulse_o) rel_seen++;
    if (long_pulse_o) long_seen++;
    if (press_pulse_o && release_pulse_o) overlap_seen++;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      SIG_PRESS: return press_pulse_o;
      SIG_REL:   return release_pulse_o;
      default:   return long_pulse_o;
    endcase
  endfunction

  // Ticks until the selected pulse is seen; -1 if it never arrives.
  task automatic wait_for(input int which, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (sig(which)) begin
        n = i;
        return;
      end
    end
  endtask

  function automatic vec_t mk(input logic raw, input logic ec, input logic cc,
                              input logic [5:0] flags, input int cnt);
    vec_t v;
    v.raw = raw; v.evt_clr = ec; v.cnt_clr = cc; v.flags = flags; v.cnt = cnt;
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    int   n;
    int   np;
    int   nl;
    int   rel0;
    int   exp_cnt;
    logic [5:0] obs;

    // Bounces: three low cycles then one high, five times; never long enough to accept.
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b0, 1'b0, 1'b0, 6'b000000, 0));
      tbl.push_back(mk(1'b1, 1'b0, 1'b0, 6'b000000, 0));
    end
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b1, 1'b0, 1'b0, 6'b000000, 0));
    // Clean press: pulse after edge 6.
    for (int i = 0; i < 6; i++) tbl.push_back(mk(1'b0, 1'b0, 1'b0, 6'b000000, 0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 6'b110010, 1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 6'b100010, 1));
    // Clean release: pulse 6 edges after the pin goes high.
    for (int i = 0; i < 6; i++) tbl.push_back(mk(1'b1, 1'b0, 1'b0, 6'b100010, 1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 6'b001010, 1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 6'b000010, 1));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 6'b000000, 1));

    rst_n_i = 1'b0; key_raw_i = 1'b1; evt_clr_i = 1'b0; cnt_clr_i = 1'b0;
    tick(); tick();
    chk("reset state",
        longint'({key_level_o, press_pulse_o, release_pulse_o, long_pulse_o,
                  press_evt_o, long_evt_o, press_cnt_o}), 0);
    rst_n_i = 1'b1;

    foreach (tbl[i]) begin
      key_raw_i = tbl[i].raw;
      evt_clr_i = tbl[i].evt_clr;
      cnt_clr_i = tbl[i].cnt_clr;
      tick();
      obs = {key_level_o, press_pulse_o, release_pulse_o, long_pulse_o, press_evt_o, long_evt_o};
      checks++;
      if (obs != tbl[i].flags || int'(press_cnt_o) != tbl[i].cnt) begin
        errors++;
        $display("FAIL table row %0d: got flags=%b cnt=%0d expected flags=%b cnt=%0d",
                 i, obs, press_cnt_o, tbl[i].flags, tbl[i].cnt);
      end
    end
    evt_clr_i = 1'b0; cnt_clr_i = 1'b0;
    exp_cnt = 1;

    // Long press, optional auto-repeat, release.
    key_raw_i = 1'b0;
    wait_for(SIG_PRESS, 20, n);
    chk("A press latency", n, 7);
    exp_cnt++;
    tick();
    chk("A press width", press_pulse_o, 0);
    wait_for(SIG_LONG, 40, n);
    chk("A long latency", n, 15);
    chk("A long_evt", long_evt_o, 1);
    tick();
    chk("A long width", long_pulse_o, 0);
    np = 0; nl = 0;
    for (int i = 0; i < 39; i++) begin
      tick();
      if (press_pulse_o) np++;
      if (long_pulse_o) nl++;
    end
    chk("A repeat pulses", np, EXP_REPEATS);
    chk("A single long", nl, 0);
    exp_cnt += EXP_REPEATS;
    chk("A press_cnt", press_cnt_o, exp_cnt);
    key_raw_i = 1'b1;
    wait_for(SIG_REL, 20, n);
    chk("A release latency", n, 7);
    chk("A level after release", key_level_o, 0);

    // Release glitch in PRESSED: no release, hold count resumes (long 3 cycles later).
    key_raw_i = 1'b0;
    wait_for(SIG_PRESS, 20, n);
    chk("B press latency", n, 7);
    exp_cnt++;
    rel0 = rel_seen;
    tick(); tick(); tick();
    key_raw_i = 1'b1;
    tick(); tick();
    key_raw_i = 1'b0;
    wait_for(SIG_LONG, 40, n);
    chk("B long after glitch", n, 14);
    chk("B no release on glitch", rel_seen - rel0, 0);
    chk("B level held", key_level_o, 1);
    chk("B press_cnt", press_cnt_o, exp_cnt);
    key_raw_i = 1'b1;
    wait_for(SIG_REL, 20, n);
    chk("B release latency", n, 7);

    // Reset during debounce with the pin still held.
    key_raw_i = 1'b0;
    tick(); tick(); tick(); tick();
    rst_n_i = 1'b0;
    tick();
    chk("D outputs in reset",
        longint'({key_level_o, press_pulse_o, release_pulse_o, long_pulse_o,
                  press_evt_o, long_evt_o, press_cnt_o}), 0);
    rst_n_i = 1'b1;
    wait_for(SIG_PRESS, 20, n);
    chk("D press after reset", n, 7);
    exp_cnt = 1;
    chk("D press_cnt", press_cnt_o, exp_cnt);
    key_raw_i = 1'b1;
    wait_for(SIG_REL, 20, n);
    chk("D release latency", n, 7);

    // Clear priorities against a coincident press.
    key_raw_i = 1'b0;
    tick(); tick();
    evt_clr_i = 1'b1;
    tick();
    evt_clr_i = 1'b0;
    chk("C evt_clr alone", press_evt_o, 0);
    tick(); tick(); tick();
    evt_clr_i = 1'b1; cnt_clr_i = 1'b1;
    tick();
    chk("C press on clr edge", press_pulse_o, 1);
    chk("C cnt keeps press", press_cnt_o, 1);
    chk("C evt set wins", press_evt_o, 1);
    cnt_clr_i = 1'b0;
    tick();
    evt_clr_i = 1'b0;
    chk("C evt cleared", press_evt_o, 0);
    chk("C cnt held", press_cnt_o, 1);
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;
    chk("C cnt_clr alone", press_cnt_o, 0);
    key_raw_i = 1'b1;
    wait_for(SIG_REL, 20, n);
    chk("C release latency", n, 7);
    tick();

    chk("total press pulses", press_seen, 5 + EXP_REPEATS);
    chk("total release pulses", rel_seen, 5);
    chk("total long pulses", long_seen, 2);
    chk("press/release overlap", overlap_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
